// File: rtl/fredkin_serial_adder.sv
// Bit-serial WIDTH-bit adder built around a Fredkin-gate full adder.
// Operands are shifted LSB first through one cswap_fa; a carry flop
// links successive bits. Valid/ready handshakes on both sides.
// Optional macro FSA_SUB_EN adds a 'sub' input for two's-complement a - b.

// Fredkin gate: passes c through, swaps x/y when c is high.
module cswap (
  input  logic c,
  input  logic x,
  input  logic y,
  output logic p,
  output logic q,
  output logic r
);
  assign p = c;
  assign q = (c & y) | (~c & x);
  assign r = (c & x) | (~c & y);
endmodule

// Reversible full adder made from five Fredkin gates with constant inputs.
module cswap_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic nb, axb, nci;
  logic unused_p1, unused_r1, unused_p2, unused_r2;
  logic unused_p3, unused_r3, unused_p4, unused_r4, unused_p5, unused_r5;

  // nb = ~b
  cswap g1 (.c(b),   .x(1'b1), .y(1'b0), .p(unused_p1), .q(nb),  .r(unused_r1));
  // axb = a ^ b
  cswap g2 (.c(a),   .x(b),    .y(nb),   .p(unused_p2), .q(axb), .r(unused_r2));
  // nci = ~ci
  cswap g3 (.c(ci),  .x(1'b1), .y(1'b0), .p(unused_p3), .q(nci), .r(unused_r3));
  // s = a ^ b ^ ci
  cswap g4 (.c(axb), .x(ci),   .y(nci),  .p(unused_p4), .q(s),   .r(unused_r4));
  // co = (a ^ b) ? ci : a
  cswap g5 (.c(axb), .x(a),    .y(ci),   .p(unused_p5), .q(co),  .r(unused_r5));
endmodule

module fredkin_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef FSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, b_load, sum_next;
  logic [CW-1:0]    cnt;
  logic             carry, cin_load, fa_s, fa_cout;

  cswap_fa u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_cout));

`ifdef FSA_SUB_EN
  // Subtract mode selects ~b and a forced carry-in of 1, all via Fredkin gates.
  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    logic nb_i;
    logic unused_pa, unused_ra, unused_pb, unused_rb;
    cswap u_not (.c(b[i]), .x(1'b1), .y(1'b0), .p(unused_pa), .q(nb_i),      .r(unused_ra));
    cswap u_sel (.c(sub),  .x(b[i]), .y(nb_i), .p(unused_pb), .q(b_load[i]), .r(unused_rb));
  end
  logic unused_pc, unused_rc;
  cswap u_csel (.c(sub), .x(cin), .y(1'b1), .p(unused_pc), .q(cin_load), .r(unused_rc));
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  // New sum bit enters at the MSB so the LSB-first stream ends up aligned.
  if (WIDTH == 1) begin : g_sum1
    assign sum_next = fa_s;
  end else begin : g_sumn
    assign sum_next = {fa_s, sum[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake decode; in_ready/out_valid come straight from state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit pair per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= cin_load;
            sum   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          sum   <= sum_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) cout <= fa_cout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fredkin_serial_adder.sv
// Directed self-checking bench for fredkin_serial_adder (WIDTH=8).
// Define FSA_SUB_EN to also exercise the subtract path.
module tb_fredkin_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef FSA_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  int lat;

  fredkin_serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef FSA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set at a falling edge and hold it across one accept edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input logic sv);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
`ifdef FSA_SUB_EN
    sub = sv;
`endif
    @(negedge clk);
    in_valid = 1'b0;
`ifdef FSA_SUB_EN
    sub = 1'b0;
`endif
  endtask

  // Count falling edges until out_valid rises, bounded.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_reached", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    logic sv0;
    sv0 = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {24'd0, sum}, 32'h00);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x35 + 0x4A: latency WIDTH, then back to IDLE
    out_ready = 1'b1;
    applyStimulus(8'h35, 8'h4A, 1'b0, sv0);
    checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
    waitDone(lat);
    checkOutput("latency", lat, W);
    checkOutput("add1_sum", {24'd0, sum}, 32'h7F);
    checkOutput("add1_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    checkOutput("add1_idle_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("add1_idle_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("add1_sum_hold", {24'd0, sum}, 32'h7F);

    // 0xFF + 0x01 wraps with carry out
    applyStimulus(8'hFF, 8'h01, 1'b0, sv0);
    waitDone(lat);
    checkOutput("add2_sum", {24'd0, sum}, 32'h00);
    checkOutput("add2_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);

    // 0xFF + 0xFF + 1 = 0x1FF
    applyStimulus(8'hFF, 8'hFF, 1'b1, sv0);
    waitDone(lat);
    checkOutput("add3_sum", {24'd0, sum}, 32'hFF);
    checkOutput("add3_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, sv0);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitDone(lat);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_sum", {24'd0, sum}, 32'h46);
      checkOutput("bp_cout", {31'd0, cout}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset three cycles after accept
    applyStimulus(8'hAA, 8'h55, 1'b0, sv0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_sum", {24'd0, sum}, 32'h00);
    checkOutput("mid_rst_cout", {31'd0, cout}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0, sv0);
    waitDone(lat);
    checkOutput("post_rst_sum", {24'd0, sum}, 32'h02);
    checkOutput("post_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

`ifdef FSA_SUB_EN
    // 0x10 - 0x01: no borrow
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
    waitDone(lat);
    checkOutput("sub1_sum", {24'd0, sum}, 32'h0F);
    checkOutput("sub1_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);

    // 0x01 - 0x02: borrow
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
    waitDone(lat);
    checkOutput("sub2_sum", {24'd0, sum}, 32'hFF);
    checkOutput("sub2_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
